// File: rtl/fp_mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency, no-backpressure FP multiplier among N_REQ requesters.
// Optional performance counters are compiled in when FPMUL_ARB_PERF_EN is defined.
module fp_mul_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef FPMUL_ARB_PERF_EN
    input  logic                       i_perf_clr,
    output logic [31:0]                o_perf_issue_cnt,
    output logic [31:0]                o_perf_stall_cnt,
`endif
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [32*N_REQ-1:0]        i_req_in1,
    input  logic [32*N_REQ-1:0]        i_req_in2,
    input  logic [3*N_REQ-1:0]         i_req_rm,
    output logic                       o_mul_valid_in,
    output logic [31:0]                o_mul_in1,
    output logic [31:0]                o_mul_in2,
    output logic [2:0]                 o_mul_rm,
    input  logic [31:0]                i_mul_out,
    input  logic [3:0]                 i_mul_flags,
    input  logic                       i_mul_valid_out,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   o_rsp_id,
    output logic [31:0]                o_rsp_data,
    output logic [3:0]                 o_rsp_flags
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned EW  = IDW + 36;

    logic [31:0]      w_in1_arr [N_REQ];
    logic [31:0]      w_in2_arr [N_REQ];
    logic [2:0]       w_rm_arr  [N_REQ];

    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_credit;
    logic             w_can_grant;
    logic             w_gnt_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic [IDW:0]     w_sum;
    logic             w_issue;

    logic             r_mul_valid;
    logic [31:0]      r_mul_in1;
    logic [31:0]      r_mul_in2;
    logic [2:0]       r_mul_rm;
    logic [IDW-1:0]   r_mul_id;

    logic             r_tag_vld [LATENCY];
    logic [IDW-1:0]   r_tag_id  [LATENCY];

    logic [EW-1:0]    r_fifo [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Unpack the flat per-requester operand buses.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_in1_arr[gi] = i_req_in1[32*gi +: 32];
        assign w_in2_arr[gi] = i_req_in2[32*gi +: 32];
        assign w_rm_arr[gi]  = i_req_rm[3*gi +: 3];
    end

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N_REQ)) begin
                w_sum = w_sum - (IDW+1)'(N_REQ);
            end
            if (!w_gnt_found && i_req_valid[w_sum[IDW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_sum[IDW-1:0];
            end
        end
    end

    // Reset gates the grant so every output reads zero while rst is held.
    assign w_can_grant = !rst && (r_credit != '0);
    assign w_issue     = w_can_grant && w_gnt_found;
    assign o_req_ready = w_issue ? (N_REQ'(1) << w_gnt_idx) : '0;

    assign w_push = i_mul_valid_out;
    assign w_pop  = (r_count != '0) && i_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_mul_valid <= 1'b0;
            r_mul_in1   <= '0;
            r_mul_in2   <= '0;
            r_mul_rm    <= '0;
            r_mul_id    <= '0;
        end else begin
            r_mul_valid <= w_issue;
            if (w_issue) begin
                r_mul_in1 <= w_in1_arr[w_gnt_idx];
                r_mul_in2 <= w_in2_arr[w_gnt_idx];
                r_mul_rm  <= w_rm_arr[w_gnt_idx];
                r_mul_id  <= w_gnt_idx;
                r_ptr     <= (w_gnt_idx == IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
            end
        end
    end

    assign o_mul_valid_in = r_mul_valid;
    assign o_mul_in1      = r_mul_in1;
    assign o_mul_in2      = r_mul_in2;
    assign o_mul_rm       = r_mul_rm;

    // Credits cover everything issued but not yet popped, so the FIFO can never overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= CW'(DEPTH);
        end else if (w_issue && !w_pop) begin
            r_credit <= r_credit - CW'(1);
        end else if (!w_issue && w_pop) begin
            r_credit <= r_credit + CW'(1);
        end
    end

    // Tag pipe loaded alongside mul_valid_in; its tail lines up with mul_valid_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_id[k]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_mul_valid;
            r_tag_id[0]  <= r_mul_id;
            for (int unsigned k = LATENCY - 1; k > 0; k--) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_fifo[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {r_tag_id[LATENCY-1], i_mul_out, i_mul_flags};
                r_wr_ptr         <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_rsp_valid = (r_count != '0);
    assign {o_rsp_id, o_rsp_data, o_rsp_flags} = r_fifo[r_rd_ptr];

`ifdef FPMUL_ARB_PERF_EN
    logic [31:0] r_perf_issue_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_issue_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else if (i_perf_clr) begin
            r_perf_issue_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
            end
            if ((|i_req_valid) && (r_credit == '0)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign o_perf_issue_cnt = r_perf_issue_cnt;
    assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_mul_valid_out && !r_tag_vld[LATENCY-1]))
                else $error("multiplier result without a matching tag");
            assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))))
                else $error("response FIFO overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_share_arbiter.sv
// Bench for fp_mul_share_arbiter: directed scenarios plus random traffic against a queue-based model,
// with a fixed-latency multiplier stand-in (exact results for the 2*3 and inf*0 cases).
module tb_fp_mul_share_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned L   = 4;
    localparam int unsigned D   = 8;
    localparam int unsigned IDW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_in1;
    logic [32*N-1:0]   req_in2;
    logic [3*N-1:0]    req_rm;
    logic              mul_valid_in;
    logic [31:0]       mul_in1, mul_in2;
    logic [2:0]        mul_rm;
    logic [31:0]       mul_out;
    logic [3:0]        mul_flags;
    logic              mul_valid_out;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data;
    logic [3:0]        rsp_flags;
`ifdef FPMUL_ARB_PERF_EN
    logic              perf_clr = 1'b0;
    logic [31:0]       perf_issue_cnt, perf_stall_cnt;
`endif

    logic [31:0] op1 [N];
    logic [31:0] op2 [N];
    logic [2:0]  oprm [N];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_in1[32*i +: 32] = op1[i];
            req_in2[32*i +: 32] = op2[i];
            req_rm[3*i +: 3]    = oprm[i];
        end
    end

    fp_mul_share_arbiter #(.N_REQ(N), .LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
`ifdef FPMUL_ARB_PERF_EN
        .i_perf_clr(perf_clr), .o_perf_issue_cnt(perf_issue_cnt), .o_perf_stall_cnt(perf_stall_cnt),
`endif
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_in1(req_in1), .i_req_in2(req_in2), .i_req_rm(req_rm),
        .o_mul_valid_in(mul_valid_in), .o_mul_in1(mul_in1), .o_mul_in2(mul_in2), .o_mul_rm(mul_rm),
        .i_mul_out(mul_out), .i_mul_flags(mul_flags), .i_mul_valid_out(mul_valid_out),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_flags(rsp_flags)
    );

    // Multiplier stand-in result: {flags, product}.
    function automatic logic [35:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return {4'b0000, 32'h40C0_0000};
        if ((a[30:0] == 31'h7F80_0000 && b[30:0] == 31'h0) || (b[30:0] == 31'h7F80_0000 && a[30:0] == 31'h0))
            return {4'b0001, 32'h7FC0_0000};
        return {a[3:0] ^ b[7:4] ^ {1'b0, r}, (a * b) ^ {b[15:0], a[31:16]}};
    endfunction

    logic        s_vld [L];
    logic [35:0] s_res [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin s_vld[k] <= 1'b0; s_res[k] <= '0; end
        end else begin
            s_vld[0] <= mul_valid_in;
            s_res[0] <= mul_ref(mul_in1, mul_in2, mul_rm);
            for (int k = 1; k < L; k++) begin s_vld[k] <= s_vld[k-1]; s_res[k] <= s_res[k-1]; end
        end
    end
    assign mul_valid_out = s_vld[L-1];
    assign mul_out       = s_res[L-1][31:0];
    assign mul_flags     = s_res[L-1][35:32];

    typedef struct { int avail; logic [IDW-1:0] id; logic [35:0] res; } exp_t;
    exp_t m_q[$];
    int   m_ptr, m_issues, m_stalls;
    bit   m_prev_issue;
    int   cyc, tests, fails, obs_acc, lat, acc_cyc;
    bit   obs_rsp_valid;
    int   obs_gnt[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op1[i] = $urandom; op2[i] = $urandom; oprm[i] = 3'($urandom_range(0, 4));
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance the model.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int g;
        bit exp_v;
        exp_t e;
        @(negedge clk);
        exp_rdy = '0;
        g = -1;
        if (!rst && m_q.size() < D)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("mul_valid_in", 64'(mul_valid_in), 64'(m_prev_issue));
        exp_v = !rst && m_q.size() > 0 && m_q[0].avail <= cyc;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            check("rsp_id", 64'(rsp_id), 64'(m_q[0].id));
            check("rsp_data", 64'(rsp_data), 64'(m_q[0].res[31:0]));
            check("rsp_flags", 64'(rsp_flags), 64'(m_q[0].res[35:32]));
        end
        obs_rsp_valid = rsp_valid;
        if (|(req_ready & req_valid)) begin
            obs_acc++;
            for (int i = 0; i < N; i++) if (req_ready[i]) obs_gnt.push_back(i);
        end
        if (!rst && |req_valid && m_q.size() == D) m_stalls++;
        if (exp_v && rsp_ready) void'(m_q.pop_front());
        m_prev_issue = (g >= 0);
        if (g >= 0) begin
            e.avail = cyc + int'(L) + 2;
            e.id    = IDW'(g);
            e.res   = mul_ref(op1[g], op2[g], oprm[g]);
            m_q.push_back(e);
            m_ptr = (g + 1) % N;
            m_issues++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        m_q.delete();
        m_ptr = 0; m_prev_issue = 1'b0; m_issues = 0; m_stalls = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_req_ready", 64'(req_ready), 64'h0);
            check("rst_mul_valid_in", 64'(mul_valid_in), 64'h0);
            check("rst_mul_ops", {mul_in1, mul_in2}, 64'h0);
            check("rst_mul_rm", 64'(mul_rm), 64'h0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
            check("rst_rsp_payload", {22'h0, rsp_id, rsp_data, rsp_flags}, 64'h0);
`ifdef FPMUL_ARB_PERF_EN
            check("rst_perf", {perf_issue_cnt, perf_stall_cnt}, 64'h0);
`endif
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin op1[i] = '0; op2[i] = '0; oprm[i] = '0; end
        #1;
        do_reset(3);

        // T1: single multiply, latency from accept to rsp_valid.
        rsp_ready = 1'b1;
        op1[0] = 32'h4000_0000; op2[0] = 32'h4040_0000; oprm[0] = 3'd0;
        req_valid = 4'b0001;
        step();
        acc_cyc = cyc - 1;
        req_valid = '0;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (lat < 0 && obs_rsp_valid) lat = (cyc - 1) - acc_cyc;
        end
        check("t1_latency", 64'(lat), 64'd6);

        // T2: all requesters active, round-robin at full rate.
        do_reset(2);
        obs_gnt.delete();
        req_valid = 4'hF;
        for (int i = 0; i < 16; i++) begin rand_ops(); step(); end
        req_valid = '0;
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 8; i++) check("t2_grant_order", 64'(obs_gnt[i]), 64'(i % 4));

        // T3: consumer stalled, credits run out after DEPTH accepts.
        do_reset(2);
        obs_acc = 0;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
        check("t3_accepts", 64'(obs_acc), 64'd8);
`ifdef FPMUL_ARB_PERF_EN
        check("t6_issue_cnt", 64'(perf_issue_cnt), 64'd8);
        check("t6_stall_cnt", 64'(perf_stall_cnt), 64'(m_stalls));
`endif
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
        req_valid = '0;
        for (int i = 0; i < 12; i++) step();
`ifdef FPMUL_ARB_PERF_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check("t6_perf_clr", {perf_issue_cnt, perf_stall_cnt}, 64'h0);
`endif

        // T4: inf * 0 from requester 2.
        op1[2] = 32'h7F80_0000; op2[2] = 32'h0000_0000; oprm[2] = 3'd0;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        for (int i = 0; i < 10; i++) step();

        // T5: reset with 3 ops in flight and 2 in the FIFO.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin rand_ops(); step(); end
        req_valid = '0;
        for (int i = 0; i < 2; i++) step();
        req_valid = 4'hF;
        do_reset(2);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        obs_acc = 0;
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        for (int i = 0; i < 14; i++) begin rand_ops(); step(); end
        check("t5_credit_restored", 64'(obs_acc), 64'd8);
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 14; i++) step();

        // Random traffic with random consumer back-pressure.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req_valid = N'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
